// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, default sizes.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_ITERS = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational conditional two's-complement negate: abs() when neg_i is the
// operand sign bit, sign restoration when neg_i is the result sign.
module mdu_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract
// step per clock over magnitudes, then a sign-fix cycle that writes HI/LO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned ITERS = MDU_ITERS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(ITERS);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] res_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;

  assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign sign_a    = is_signed & data1[WIDTH-1];
  assign sign_b    = is_signed & data2[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH)) u_abs_a (.val_i(data1), .neg_i(sign_a), .res_o(mag_a));
  mdu_sign_fix #(.W(WIDTH)) u_abs_b (.val_i(data2), .neg_i(sign_b), .res_o(mag_b));

  // Negating the whole {rem,quot} word leaves the negated quotient in the low half,
  // so one wide instance serves both product and quotient. Divide-by-zero keeps all-ones.
  mdu_sign_fix #(.W(2*WIDTH)) u_fix_res (
    .val_i(acc_q), .neg_i(neg_res_q & ~dz_q), .res_o(res_fixed)
  );
  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
    .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .res_o(rem_fixed)
  );

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              is_div_d  = op[1];
              acc_d     = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
              opnd_d    = op[1] ? mag_b : mag_a;
              neg_res_d = sign_a ^ sign_b;
              neg_rem_d = sign_a;
              dz_d      = op[1] && (data2 == '0);
              cnt_d     = '0;
              state_d   = RUN;
            end
            MDU_MTHI: hi_d = data1;
            MDU_MTLO: lo_d = data1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (is_div_q) begin
          acc_d = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = res_fixed[WIDTH-1:0];
          hi_d = rem_fixed;
        end else begin
          {hi_d, lo_d} = res_fixed;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with per-cycle compare,
// directed literal cases and a randomized op stream.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [2:0]   op      = '0;
  logic [W-1:0] data1   = '0;
  logic [W-1:0] data2   = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .data1(data1), .data2(data2), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // {hi, lo} an op must produce, straight from the arithmetic definition
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      3'd0: p = sa * sb;
      3'd1: p = {32'b0, a} * {32'b0, b};
      3'd2, 3'd3: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else if (o == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  logic        m_done;
  int          m_left;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_left <= 0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end
      end else if (start) begin
        if (op <= 3'd3) begin
          m_pend <= ref_res(op, data1, data2);
          m_left <= 33;
        end else if (op == 3'd4) m_hi <= data1;
        else if (op == 3'd5) m_lo <= data1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_busy", busy, (m_left != 0));
      chk("cyc_done", done, m_done);
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; op = o; data1 = a; data2 = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int bc);
    bc = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      if (busy) bc++;
      @(negedge clock);
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic run(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el);
    int bc;
    issue(o, a, b);
    wait_done(bc);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_busy_cycles"}, bc, 33);
    @(negedge clock);
    chk({nm, "_done_once"}, done, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    time t1, t2;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    chk_en  = 1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult_neg",  3'd0, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_zero", 3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
    run("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);

    issue(3'd4, 32'h1234_5678, 32'h0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'h8000_0000);
    chk("mthi_done", done, 1'b0);
    chk("mthi_busy", busy, 1'b0);

    issue(3'd0, 32'd5, 32'hFFFF_FFFC);
    start = 1'b1; op = 3'd5; data1 = 32'hDEAD_BEEF;
    @(negedge clock);
    start = 1'b0;
    wait_done(bc);
    chk("mtlo_busy_hi", hi, 32'hFFFF_FFFF);
    chk("mtlo_busy_lo", lo, 32'hFFFF_FFEC);

    issue(3'd3, 32'd1000, 32'd7);
    repeat (9) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_hi", hi, 32'h0);
    chk("async_rst_lo", lo, 32'h0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run("divu_after_rst", 3'd3, 32'd10, 32'd3, 32'd1, 32'd3);

    issue(3'd1, 32'd6, 32'd7);
    wait_done(bc);
    t1 = $time;
    chk("b2b_mul_hi", hi, 32'd0);
    chk("b2b_mul_lo", lo, 32'd42);
    start = 1'b1; op = 3'd3; data1 = 32'd42; data2 = 32'd5;
    @(negedge clock);
    start = 1'b0;
    wait_done(bc);
    t2 = $time;
    chk("b2b_div_hi", hi, 32'd2);
    chk("b2b_div_lo", lo, 32'd8);
    chk("b2b_gap_cycles", (t2 - t1) / 10, 34);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom_range(0, 7));
      data1 = pick();
      data2 = pick();
    end
    @(negedge clock);
    start = 1'b0;
    repeat (40) @(negedge clock);
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
